// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture front end.
package cam_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'b00,
    VBLANK = 2'b01,
    ACTIVE = 2'b10
  } cap_state_t;

  localparam int unsigned IMG_W_IN_DEF = 640;
  localparam int unsigned IMG_H_IN_DEF = 480;
  localparam int unsigned DECIM_DEF    = 4;

  localparam int unsigned OUT_W     = IMG_W_IN_DEF / DECIM_DEF;
  localparam int unsigned OUT_H     = IMG_H_IN_DEF / DECIM_DEF;
  localparam int unsigned FRAME_PIX = OUT_W * OUT_H;

  // Exponent of a power-of-two value; yields 0 for inputs that are not a power of two.
  function automatic int unsigned log2_pow2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) == v) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Camera byte stream in, frame-memory write port and frame status out.
interface cam_capture_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned PIX_W  = 8
);
  logic              cam_pclk;
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              write_en;
  logic [PIX_W-1:0]  pix_out;
  logic              cap_done;
  logic              frame_err;

  modport master (
    output cam_pclk, cam_vsync, cam_href, cam_data,
    input  wr_addr, write_en, pix_out, cap_done, frame_err
  );

  modport slave (
    input  cam_pclk, cam_vsync, cam_href, cam_data,
    output wr_addr, write_en, pix_out, cap_done, frame_err
  );
endinterface

// File: rtl/cam_sync.sv
// Two-flop synchroniser plus an edge-detect flop, per bit.
module cam_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/cam_capture.sv
// Luma capture with DECIM x DECIM decimation into frame memory; reports
// frame completion (cap_done) and malformed frames (frame_err).
module cam_capture
  import cam_pkg::*;
#(
  parameter int unsigned IMG_W_IN = IMG_W_IN_DEF,
  parameter int unsigned IMG_H_IN = IMG_H_IN_DEF,
  parameter int unsigned DECIM    = DECIM_DEF,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned PIX_W    = 8
) (
  input logic          clk,
  input logic          rst,
  cam_capture_if.slave bus
);
  localparam int unsigned OW       = IMG_W_IN / DECIM;
  localparam int unsigned OH       = IMG_H_IN / DECIM;
  localparam int unsigned FPIX     = OW * OH;
  localparam int unsigned BYTE_MAX = 2 * IMG_W_IN;
  localparam int unsigned LINE_MAX = IMG_H_IN + 1;
  localparam int unsigned BC_W     = $clog2(BYTE_MAX + 1);
  localparam int unsigned LC_W     = $clog2(LINE_MAX + 1);
  localparam int unsigned WC_W     = $clog2(FPIX + 1);
  localparam int unsigned DEC_MASK = (32'd1 << log2_pow2(DECIM)) - 1;

  logic [2:0] ctrl_q, ctrl_rise, ctrl_fall;
  logic [7:0] data_s, data_rise_unused, data_fall_unused;
  logic       ctrl_unused;

  cam_sync #(.W(3)) u_sync_ctrl (
    .clk  (clk),
    .rst  (rst),
    .d    ({bus.cam_pclk, bus.cam_vsync, bus.cam_href}),
    .q    (ctrl_q),
    .rise (ctrl_rise),
    .fall (ctrl_fall)
  );

  cam_sync #(.W(8)) u_sync_data (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.cam_data),
    .q    (data_s),
    .rise (data_rise_unused),
    .fall (data_fall_unused)
  );

  assign ctrl_unused = ^{ctrl_q[2], ctrl_rise[0], ctrl_fall[2]};

  logic vsync_s, href_s, pclk_rise, vsync_rise, vsync_fall, href_fall;
  assign vsync_s    = ctrl_q[1];
  assign href_s     = ctrl_q[0];
  assign pclk_rise  = ctrl_rise[2];
  assign vsync_rise = ctrl_rise[1];
  assign vsync_fall = ctrl_fall[1];
  assign href_fall  = ctrl_fall[0];

  cap_state_t        state_q, state_d;
  logic [BC_W-1:0]   byte_q, byte_d;
  logic [LC_W-1:0]   line_q, line_d;
  logic [WC_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              keep;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SYNC;
      byte_q    <= '0;
      line_q    <= '0;
      wr_cnt_q  <= '0;
      wr_addr_q <= '0;
      pix_q     <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      line_q    <= line_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_addr_q <= wr_addr_d;
      pix_q     <= pix_d;
      we_q      <= we_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Y byte on a kept column of a kept line, inside the line, and room left in the frame
  assign keep = !byte_q[0]
             && (((byte_q >> 1) & BC_W'(DEC_MASK)) == '0)
             && ((line_q & LC_W'(DEC_MASK)) == '0)
             && (byte_q < BC_W'(BYTE_MAX))
             && (wr_cnt_q < WC_W'(FPIX));

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    line_d    = line_q;
    wr_cnt_d  = wr_cnt_q;
    wr_addr_d = wr_addr_q;
    pix_d     = pix_q;
    we_d      = 1'b0;
    done_d    = done_q;
    err_d     = 1'b0;
    case (state_q)
      SYNC: begin
        if (vsync_s) state_d = VBLANK;
      end
      VBLANK: begin
        if (vsync_fall) begin
          byte_d   = '0;
          line_d   = '0;
          wr_cnt_d = '0;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        // vsync rise wins over any href/pclk activity in the same cycle
        if (vsync_rise) begin
          state_d = VBLANK;
          if (line_q == LC_W'(IMG_H_IN) && wr_cnt_q == WC_W'(FPIX)) done_d = 1'b1;
          else err_d = 1'b1;
        end else if (pclk_rise && href_s) begin
          if (keep) begin
            we_d      = 1'b1;
            pix_d     = PIX_W'(data_s);
            wr_addr_d = ADDR_W'(wr_cnt_q);
            wr_cnt_d  = wr_cnt_q + 1'b1;
            done_d    = 1'b0;
          end
          if (byte_q != BC_W'(BYTE_MAX)) byte_d = byte_q + 1'b1;
        end else if (href_fall) begin
          byte_d = '0;
          if (line_q != LC_W'(LINE_MAX)) line_d = line_q + 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  assign bus.wr_addr   = wr_addr_q;
  assign bus.write_en  = we_q;
  assign bus.pix_out   = pix_q;
  assign bus.cap_done  = done_q;
  assign bus.frame_err = err_q;
endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Camera front end feeding detection_sm and the shared frame memory.
- Samples an OV7670-style YUV422 byte stream (pclk/vsync/href/data) in the system clock domain.
- Keeps only the Y (luma) bytes and decimates 640x480 down to 160x120.
- Emits one memory write per kept pixel (wr_addr / write_en / pix_out) and a frame-status level, cap_done, in the form detection_sm consumes.

Parameters:
- IMG_W_IN, 640, active pixels per camera line (2 bytes per pixel).
- IMG_H_IN, 480, active lines per camera frame.
- DECIM, 4, horizontal and vertical decimation factor; must be a power of 2.
- ADDR_W, 15, memory address width; (IMG_W_IN/DECIM)*(IMG_H_IN/DECIM) must be at most 2^ADDR_W.
- PIX_W, 8, output pixel width.

Ports:
- clk  in  1  system clock; must be at least 4x cam_pclk frequency.
- rst  in  1  synchronous, active-high reset.
- cam_pclk  in  1  camera pixel clock, asynchronous; sampled as data, not used as a clock.
- cam_vsync  in  1  frame sync, high during vertical blanking.
- cam_href  in  1  line valid.
- cam_data  in  8  camera byte.
- wr_addr  out  ADDR_W  write address; equals row*(IMG_W_IN/DECIM)+col.
- write_en  out  1  one-cycle write strobe.
- pix_out  out  PIX_W  luma value written.
- cap_done  out  1  level: a complete frame is held in memory and no new frame write has started.
- frame_err  out  1  one-cycle pulse when a frame ends with the wrong line or pixel count.

Behaviour:
- Input synchronisation:
  - cam_pclk, cam_vsync, cam_href and cam_data pass through 2 flops each, with a 3rd flop for edge detection.
  - A pclk rising edge is detected in the cycle where sync2=1 and sync3=0. Only one byte is taken per detected edge.
- Reset values: wr_addr=0, write_en=0, pix_out=0, cap_done=0, frame_err=0, state=SYNC, all counters 0.
- State machine:
  - SYNC: wait for synced vsync=1, then go to VBLANK. A reset mid-frame therefore never produces a partial frame.
  - VBLANK: on a vsync falling edge, clear byte_cnt, line_cnt and wr_cnt, then go to ACTIVE.
  - ACTIVE:
    - On each pclk edge with href=1: if byte_cnt[0]==0 (Y byte), and (byte_cnt>>1)%DECIM==0, and line_cnt%DECIM==0, and byte_cnt<2*IMG_W_IN, then write the pixel.
    - byte_cnt increments on every href=1 pclk edge and saturates at 2*IMG_W_IN.
    - On an href falling edge: line_cnt increments (saturating at IMG_H_IN+1) and byte_cnt is cleared.
    - On a vsync rising edge: go to VBLANK and check the frame.
- Frame check, on the vsync rising edge in ACTIVE:
  - Good frame: line_cnt==IMG_H_IN and wr_cnt==(IMG_W_IN/DECIM)*(IMG_H_IN/DECIM). Set cap_done=1 in the next cycle.
  - Otherwise: pulse frame_err for 1 cycle and leave cap_done unchanged.
- Pixel write:
  - write_en=1 for exactly 1 cycle, in the cycle after the detected edge.
  - pix_out is the synced byte truncated or zero-extended to PIX_W.
  - wr_addr equals wr_cnt, which then increments.
  - Latency is 3 clk from the first clk edge that samples cam_pclk high to write_en high.
  - wr_addr holds its value between writes.
- cap_done:
  - Cleared in the same cycle as the first write_en of a frame; set again only by a good-frame check.
  - This gives a rising edge per good frame, which detection_sm requires.
  - A bad frame leaves cap_done at 0, so detection_sm stays in CAPTURE until the next good frame.
- Lines beyond IMG_H_IN: no writes occur, since line_cnt saturates and the decimation test fails or wr_cnt is capped. wr_cnt never exceeds the frame size and never wraps.
- A vsync rising edge and an href edge in the same cycle: vsync takes priority and href is ignored.

Decomposition:
- Package cam_pkg holds:
  - state encoding SYNC=2'b00, VBLANK=2'b01, ACTIVE=2'b10;
  - derived constants OUT_W=IMG_W_IN/DECIM, OUT_H=IMG_H_IN/DECIM, FRAME_PIX=OUT_W*OUT_H;
  - log2(DECIM).
- Sub-module cam_sync: parameterised-width 2-flop synchroniser plus 3rd flop, with rise and fall outputs. Instantiated once for pclk/vsync/href and once for the data bus.

Test Plan (IMG_W_IN=8, IMG_H_IN=8, DECIM=2; pclk = clk/4):
- Reset, then a full frame with Y bytes = line*16+pixel -> 16 write_en pulses at addresses 0..15; pix_out at addr 5 = 0x22; cap_done rises 1 cycle after the vsync rise; frame_err stays 0.
- Second good frame -> cap_done falls in the cycle of the first write_en (addr 0) and rises again after the vsync rise.
- Frame with only 6 href lines -> 12 writes, 1-cycle frame_err, cap_done stays 0.
- Assert rst during line 3 of an active frame, then release -> no writes until the vsync high/low sequence; the following frame is good, writing addresses 0..15.
- Lines of 12 pixels and 10 lines -> at most 16 writes, wr_addr never exceeds 15, frame_err pulses.
- Check that every write_en occurs exactly 3 clk after the first sampled pclk high, and that no two write_en pulses fall in adjacent cycles.
